// File: rtl/ram_dp_sync_read.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_sync_read
// Description : Simple dual-port RAM with one write port and one read port on a
//               single clock. Per-byte write enables, registered read with a
//               valid strobe, and a selectable read-during-write policy.
//               Define RAM_DP_OUTPUT_REG_EN to add a second output stage
//               (read latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_sync_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int                c_bytes = DATA_WIDTH / 8;
    localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_depth = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [c_idx_w-1:0]    w_wr_idx;
    logic [c_idx_w-1:0]    w_rd_idx;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_collide;

    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    // Range checks use the full address so out-of-range never aliases.
    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
    assign w_wr_idx      = wr_addr[c_idx_w-1:0];
    assign w_rd_idx      = rd_addr[c_idx_w-1:0];
    assign w_old_word    = w_rd_in_range ? r_mem[w_rd_idx] : '0;
    assign w_collide     = wr_en && w_wr_in_range && w_rd_in_range && (wr_addr == rd_addr);

    generate
        for (genvar g = 0; g < c_bytes; g++) begin : g_merge
            assign w_merged[8*g +: 8] = wr_be[g] ? wr_data[8*g +: 8] : w_old_word[8*g +: 8];
        end
    endgenerate

    generate
        if (RDW_MODE == 1) begin : g_write_first
            assign w_rd_word = w_collide ? w_merged : w_old_word;
        end else begin : g_read_first
            assign w_rd_word = w_old_word;
        end
    endgenerate

    // Memory array is intentionally not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && w_wr_in_range) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (wr_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= rd_en;
            if (rd_en) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

`ifdef RAM_DP_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_data;
            end
        end
    end

    assign rd_data  = r_s2_data;
    assign rd_valid = r_s2_valid;
`else
    assign rd_data  = r_s1_data;
    assign rd_valid = r_s1_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_sync_read.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_sync_read
// Description : Directed self-checking bench for ram_dp_sync_read. Instance A
//               is 8-bit / read-first with a 5-bit address; instance B is
//               32-bit / write-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_sync_read;

`ifdef RAM_DP_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_wr_en = 1'b0;
    logic [4:0]  a_wr_addr = '0;
    logic [7:0]  a_wr_data = '0;
    logic [0:0]  a_wr_be = '0;
    logic        a_rd_en = 1'b0;
    logic [4:0]  a_rd_addr = '0;
    logic [7:0]  a_rd_data;
    logic        a_rd_valid;

    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic [3:0]  b_wr_be = '0;
    logic        b_rd_en = 1'b0;
    logic [3:0]  b_rd_addr = '0;
    logic [31:0] b_rd_data;
    logic        b_rd_valid;

    ram_dp_sync_read #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16), .RDW_MODE(0)) u_dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
    );

    ram_dp_sync_read #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RDW_MODE(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_a [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [7:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = 1'b1;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
        tick();
        b_wr_en = 1'b0;
    endtask

    // Issues one read and returns once the result is on the outputs.
    task automatic a_read(input logic [4:0] addr);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic b_read(input logic [3:0] addr);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (a_rd_data !== 8'h00) begin fails++; $display("FAIL reset_a_data: got %h expected 00", a_rd_data); end
        checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid: got %b expected 0", a_rd_valid); end
        checks++; if (b_rd_data !== 32'h0) begin fails++; $display("FAIL reset_b_data: got %h expected 0", b_rd_data); end
        checks++; if (b_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b expected 0", b_rd_valid); end
        reset = 1'b0;
        a_write(5'd3, 8'hA5);
        a_rd_en = 1'b1; a_rd_addr = 5'd3;
        tick();
        a_rd_en = 1'b0;
        if (LAT == 2) begin
            checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL latency_early_valid: got %b expected 0", a_rd_valid); end
            tick();
        end
        checks++; if (a_rd_valid !== 1'b1) begin fails++; $display("FAIL first_read_valid: got %b expected 1", a_rd_valid); end
        checks++; if (a_rd_data !== 8'hA5) begin fails++; $display("FAIL first_read_data: got %h expected a5", a_rd_data); end
    endtask

    task automatic test_byte_enable();
        b_write(4'd2, 32'h11223344, 4'b1111);
        b_write(4'd2, 32'hAABBCCDD, 4'b0101);
        b_read(4'd2);
        checks++; if (b_rd_data !== 32'h11BB33DD) begin fails++; $display("FAIL byte_enable_merge: got %h expected 11bb33dd", b_rd_data); end
        checks++; if (b_rd_valid !== 1'b1) begin fails++; $display("FAIL byte_enable_valid: got %b expected 1", b_rd_valid); end
        b_write(4'd2, 32'hFFFFFFFF, 4'b0000);
        b_read(4'd2);
        checks++; if (b_rd_data !== 32'h11BB33DD) begin fails++; $display("FAIL byte_enable_zero: got %h expected 11bb33dd", b_rd_data); end
    endtask

    task automatic test_collision();
        a_write(5'd5, 8'h3C);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 8'hC3; a_wr_be = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 5'd5;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        checks++; if (a_rd_data !== 8'h3C) begin fails++; $display("FAIL rdw_read_first: got %h expected 3c", a_rd_data); end
        a_read(5'd5);
        checks++; if (a_rd_data !== 8'hC3) begin fails++; $display("FAIL rdw_read_first_follow: got %h expected c3", a_rd_data); end

        b_write(4'd5, 32'h0000003C, 4'b1111);
        b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 32'h000000C3; b_wr_be = 4'b1111;
        b_rd_en = 1'b1; b_rd_addr = 4'd5;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        checks++; if (b_rd_data !== 32'h000000C3) begin fails++; $display("FAIL rdw_write_first: got %h expected 000000c3", b_rd_data); end
        b_read(4'd5);
        checks++; if (b_rd_data !== 32'h000000C3) begin fails++; $display("FAIL rdw_write_first_follow: got %h expected 000000c3", b_rd_data); end

        // Partial-byte collision in write-first mode returns the merged word.
        b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 32'h12345678; b_wr_be = 4'b1010;
        b_rd_en = 1'b1; b_rd_addr = 4'd5;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        checks++; if (b_rd_data !== 32'h120056C3) begin fails++; $display("FAIL rdw_write_first_partial: got %h expected 120056c3", b_rd_data); end

        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 8'h77; a_wr_be = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 5'd3;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        repeat (LAT - 1) tick();
        checks++; if (a_rd_data !== 8'hA5) begin fails++; $display("FAIL diff_addr_read: got %h expected a5", a_rd_data); end
        a_read(5'd6);
        checks++; if (a_rd_data !== 8'h77) begin fails++; $display("FAIL diff_addr_write: got %h expected 77", a_rd_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            exp_a[i] = 8'(8'h40 + 8'(i) * 8'h1D);
            a_write(5'(i), exp_a[i]);
        end
        for (int i = 0; i < 16 + LAT - 1; i++) begin
            if (i < 16) begin
                a_rd_en = 1'b1; a_rd_addr = 5'(i);
            end else begin
                a_rd_en = 1'b0;
            end
            tick();
            if (i >= LAT - 1) begin
                checks++; if (a_rd_valid !== 1'b1) begin fails++; $display("FAIL sweep_valid[%0d]: got %b expected 1", i - (LAT - 1), a_rd_valid); end
                checks++; if (a_rd_data !== exp_a[i - (LAT - 1)]) begin fails++; $display("FAIL sweep_data[%0d]: got %h expected %h", i - (LAT - 1), a_rd_data, exp_a[i - (LAT - 1)]); end
            end
        end
        a_rd_en = 1'b0;
        tick();
        checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL sweep_end_valid: got %b expected 0", a_rd_valid); end

        a_write(5'd16, 8'hFF);
        a_read(5'd0);
        checks++; if (a_rd_data !== exp_a[0]) begin fails++; $display("FAIL oob_write_no_wrap: got %h expected %h", a_rd_data, exp_a[0]); end
        a_read(5'd16);
        checks++; if (a_rd_data !== 8'h00) begin fails++; $display("FAIL oob_read_data: got %h expected 00", a_rd_data); end
        checks++; if (a_rd_valid !== 1'b1) begin fails++; $display("FAIL oob_read_valid: got %b expected 1", a_rd_valid); end
    endtask

    task automatic test_reset_midstream();
        a_rd_en = 1'b1; a_rd_addr = 5'd7;
        tick();
        a_rd_en = 1'b0;
        reset = 1'b1;
        // A write during reset must be ignored.
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 8'h00; a_wr_be = 1'b1;
        tick();
        a_wr_en = 1'b0;
        checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 8'h00) begin fails++; $display("FAIL midreset_data: got %h expected 00", a_rd_data); end
        tick();
        checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid_hold: got %b expected 0", a_rd_valid); end
        reset = 1'b0;
        a_read(5'd7);
        checks++; if (a_rd_data !== exp_a[7]) begin fails++; $display("FAIL post_reset_read: got %h expected %h", a_rd_data, exp_a[7]); end
    endtask

    task automatic test_rd_en_hold();
        a_write(5'd9, 8'h5A);
        a_read(5'd9);
        checks++; if (a_rd_data !== 8'h5A) begin fails++; $display("FAIL hold_first: got %h expected 5a", a_rd_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL hold_valid[%0d]: got %b expected 0", i, a_rd_valid); end
            checks++; if (a_rd_data !== 8'h5A) begin fails++; $display("FAIL hold_data[%0d]: got %h expected 5a", i, a_rd_data); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_reset_midstream();
        test_rd_en_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
